// File: rtl/hazard_pkg.sv
// Shared constants and helper functions for the pipeline hazard controller.
package hazard_pkg;

    typedef logic [4:0] reg_addr_t;

    localparam logic [1:0] FWD_NONE = 2'd0;
    localparam logic [1:0] FWD_W    = 2'd1;
    localparam logic [1:0] FWD_M    = 2'd2;
    localparam logic [1:0] FWD_E    = 2'd3;

    localparam logic [1:0] TUSE_NONE = 2'd3;

    localparam int STAGE_D = 0;
    localparam int STAGE_E = 1;
    localparam int STAGE_M = 2;
    localparam int STAGE_W = 3;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    // Nearest ready producer wins; e_ok is cleared for consumers already past E.
    function automatic logic [1:0] fwd_select(
        input reg_addr_t  src,
        input logic       e_ok,
        input reg_addr_t  e_dst,
        input logic [1:0] e_tnew,
        input reg_addr_t  m_dst,
        input logic [1:0] m_tnew,
        input reg_addr_t  w_dst
    );
        logic [1:0] sel;
        sel = FWD_NONE;
        if (src != 5'd0) begin
            if (e_ok && src == e_dst && e_tnew == 2'd0) begin
                sel = FWD_E;
            end else if (src == m_dst && m_tnew == 2'd0) begin
                sel = FWD_M;
            end else if (src == w_dst) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    function automatic logic data_hazard(
        input reg_addr_t  src,
        input logic [1:0] tuse,
        input reg_addr_t  e_dst,
        input logic [1:0] e_tnew,
        input reg_addr_t  m_dst,
        input logic [1:0] m_tnew
    );
        return (src != 5'd0) &&
               ((src == e_dst && e_tnew > tuse) ||
                (src == m_dst && m_tnew > tuse));
    endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_ctr.sv
// Multiply/divide busy window: loads on an MDU start in E, then counts down.
module md_busy_ctr
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy
);

    localparam int MAX_CYCLES = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (start) begin
            count_next = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign busy = (count_reg != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/forward scheduler: shadows E/M/W destinations and compares them with the D instruction.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_rs_tuse,
    input  logic [1:0] d_rt_tuse,
    input  logic [4:0] d_dst,
    input  logic [1:0] d_tnew,
    input  logic       d_md_use,
    input  logic       d_md_start,
    input  logic       d_md_div,
    output logic       stall,
    output logic [1:0] fwd_rs_d,
    output logic [1:0] fwd_rt_d,
    output logic [1:0] fwd_rs_e,
    output logic [1:0] fwd_rt_e,
    output logic       fwd_rt_m,
    output logic       md_busy
);

    reg_addr_t  dst_reg  [STAGE_E:STAGE_W];
    logic [1:0] tnew_reg [STAGE_E:STAGE_M];
    reg_addr_t  rt_reg   [STAGE_E:STAGE_M];
    reg_addr_t  e_rs_reg;
    logic       e_md_start_reg;
    logic       e_md_div_reg;

    reg_addr_t  d_src  [2];
    logic [1:0] d_tuse [2];
    reg_addr_t  e_src  [2];
    logic [1:0] fwd_d  [2];
    logic [1:0] fwd_e  [2];
    logic [1:0] data_stall;
    logic       md_stall;

    assign d_src[0]  = d_rs;
    assign d_src[1]  = d_rt;
    assign d_tuse[0] = d_rs_tuse;
    assign d_tuse[1] = d_rt_tuse;
    assign e_src[0]  = e_rs_reg;
    assign e_src[1]  = rt_reg[STAGE_E];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign data_stall[gi] = data_hazard(d_src[gi], d_tuse[gi],
                                                dst_reg[STAGE_E], tnew_reg[STAGE_E],
                                                dst_reg[STAGE_M], tnew_reg[STAGE_M]);
            // A source that is never read must not pick up a forward.
            assign fwd_d[gi] = (d_tuse[gi] == TUSE_NONE) ? FWD_NONE :
                               fwd_select(d_src[gi], 1'b1,
                                          dst_reg[STAGE_E], tnew_reg[STAGE_E],
                                          dst_reg[STAGE_M], tnew_reg[STAGE_M],
                                          dst_reg[STAGE_W]);
            assign fwd_e[gi] = fwd_select(e_src[gi], 1'b0,
                                          dst_reg[STAGE_E], tnew_reg[STAGE_E],
                                          dst_reg[STAGE_M], tnew_reg[STAGE_M],
                                          dst_reg[STAGE_W]);
        end
    endgenerate

    assign md_stall = d_md_use && (md_busy || e_md_start_reg);
    assign stall    = (|data_stall) || md_stall;

    assign fwd_rs_d = fwd_d[0];
    assign fwd_rt_d = fwd_d[1];
    assign fwd_rs_e = fwd_e[0];
    assign fwd_rt_e = fwd_e[1];
    assign fwd_rt_m = (rt_reg[STAGE_M] == dst_reg[STAGE_W]) && (dst_reg[STAGE_W] != 5'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            dst_reg[STAGE_E]  <= '0;
            dst_reg[STAGE_M]  <= '0;
            dst_reg[STAGE_W]  <= '0;
            tnew_reg[STAGE_E] <= '0;
            tnew_reg[STAGE_M] <= '0;
            rt_reg[STAGE_E]   <= '0;
            rt_reg[STAGE_M]   <= '0;
            e_rs_reg          <= '0;
            e_md_start_reg    <= 1'b0;
            e_md_div_reg      <= 1'b0;
        end else begin
            dst_reg[STAGE_W]  <= dst_reg[STAGE_M];
            dst_reg[STAGE_M]  <= dst_reg[STAGE_E];
            rt_reg[STAGE_M]   <= rt_reg[STAGE_E];
            tnew_reg[STAGE_M] <= (tnew_reg[STAGE_E] == 2'd0) ? 2'd0 : tnew_reg[STAGE_E] - 2'd1;
            if (stall) begin
                dst_reg[STAGE_E]  <= '0;
                tnew_reg[STAGE_E] <= '0;
                rt_reg[STAGE_E]   <= '0;
                e_rs_reg          <= '0;
                e_md_start_reg    <= 1'b0;
                e_md_div_reg      <= 1'b0;
            end else begin
                dst_reg[STAGE_E]  <= d_dst;
                tnew_reg[STAGE_E] <= d_tnew;
                rt_reg[STAGE_E]   <= d_rt;
                e_rs_reg          <= d_rs;
                e_md_start_reg    <= d_md_start;
                e_md_div_reg      <= d_md_start && d_md_div;
            end
        end
    end

    md_busy_ctr #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_busy_ctr (
        .clk    (clk),
        .reset  (reset),
        .start  (e_md_start_reg),
        .is_div (e_md_div_reg),
        .busy   (md_busy)
    );

endmodule
